// File: rtl/decoder_stage_controller_if.sv
// +--------------------------------------------------------------------------+
// | decoder_stage_controller_if : stage encodings and controller <-> PE-array |
// | handshake bundle.                                          Revision: 1.0 |
// +--------------------------------------------------------------------------+
`default_nettype none

package decoder_stage_pkg;
   localparam int STAGE_WIDTH = 3;
   localparam logic [STAGE_WIDTH-1:0] STAGE_IDLE                = 3'd0;
   localparam logic [STAGE_WIDTH-1:0] STAGE_MEASUREMENT_LOADING = 3'd1;
   localparam logic [STAGE_WIDTH-1:0] STAGE_GROW                = 3'd2;
   localparam logic [STAGE_WIDTH-1:0] STAGE_MERGE               = 3'd3;
   localparam logic [STAGE_WIDTH-1:0] STAGE_RESULT_VALID        = 3'd4;
endpackage

interface decoder_stage_controller_if #(
   parameter int ITER_WIDTH  = 5,
   parameter int CYCLE_WIDTH = 16
);
   logic                                   measurements_valid;
   logic                                   measurements_ready;
   logic                                   busy_any;
   logic                                   odd_any;
   logic [decoder_stage_pkg::STAGE_WIDTH-1:0] global_stage;
   logic [ITER_WIDTH-1:0]                  iteration_count;
   logic                                   result_valid;
   logic                                   result_ack;
   logic                                   decode_error;
   logic [CYCLE_WIDTH-1:0]                 total_cycles;
   logic [CYCLE_WIDTH-1:0]                 merge_cycles;

   modport master (
      input  measurements_valid, busy_any, odd_any, result_ack,
      output measurements_ready, global_stage, iteration_count, result_valid,
             decode_error, total_cycles, merge_cycles
   );

   modport slave (
      output measurements_valid, busy_any, odd_any, result_ack,
      input  measurements_ready, global_stage, iteration_count, result_valid,
             decode_error, total_cycles, merge_cycles
   );
endinterface

`default_nettype wire

// File: rtl/decoder_stage_controller.sv
// +--------------------------------------------------------------------------+
// | decoder_stage_controller : global LOAD/GROW/MERGE/RESULT sequencer for the|
// | union-find PE array. Optional STAGE_CTRL_STATS_EN adds cycle statistics.  |
// |                                                            Revision: 1.0 |
// +--------------------------------------------------------------------------+
`default_nettype none

module decoder_stage_controller #(
   parameter int GROW_CYCLES     = 2,
   parameter int BUSY_PIPE_DEPTH = 1,
   parameter int MERGE_QUIET     = 3,
   parameter int MAX_ITERATIONS  = 31,
   parameter int ITER_WIDTH      = 5,
   parameter int CYCLE_WIDTH     = 16
) (
   input  wire logic                     clk,
   input  wire logic                     reset,
   decoder_stage_controller_if.master    bus
);
   import decoder_stage_pkg::*;

   localparam int SETTLE   = 2 + BUSY_PIPE_DEPTH;
   localparam int SETTLE_W = $clog2(SETTLE + 1);
   localparam int GROW_W   = $clog2(GROW_CYCLES + 1);
   localparam int QUIET_W  = $clog2(MERGE_QUIET + 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD   = 3'd1,
      S_GROW   = 3'd2,
      S_MERGE  = 3'd3,
      S_RESULT = 3'd4
   } state_t;

   state_t                 state_q, state_d;
   logic [STAGE_WIDTH-1:0] stage_q, stage_d;
   logic                   load_second_q, load_second_d;
   logic [GROW_W-1:0]      grow_cnt_q, grow_cnt_d;
   logic [SETTLE_W-1:0]    settle_q, settle_d;
   logic [QUIET_W-1:0]     quiet_q, quiet_d;
   logic [QUIET_W-1:0]     quiet_next;
   logic [ITER_WIDTH-1:0]  iter_q, iter_d, iter_inc;
   logic                   ready_q, ready_d;
   logic                   result_valid_q, result_valid_d;
   logic                   error_q, error_d;

   function automatic logic [STAGE_WIDTH-1:0] stage_of(input state_t s);
      case (s)
         S_LOAD:   stage_of = STAGE_MEASUREMENT_LOADING;
         S_GROW:   stage_of = STAGE_GROW;
         S_MERGE:  stage_of = STAGE_MERGE;
         S_RESULT: stage_of = STAGE_RESULT_VALID;
         default:  stage_of = STAGE_IDLE;
      endcase
   endfunction

   always_comb begin
      state_d       = state_q;
      load_second_d = load_second_q;
      grow_cnt_d    = grow_cnt_q;
      settle_d      = settle_q;
      quiet_d       = quiet_q;
      iter_d        = iter_q;
      error_d       = error_q;
      ready_d       = 1'b0;
      quiet_next    = bus.busy_any ? '0 : quiet_q + 1'b1;
      iter_inc      = (iter_q == '1) ? iter_q : iter_q + 1'b1;

      case (state_q)
         S_IDLE: begin
            if (bus.measurements_valid) begin
               state_d       = S_LOAD;
               load_second_d = 1'b0;
               iter_d        = '0;
            end
         end
         S_LOAD: begin
            // Two loading cycles so the PEs see the stage despite their re-register lag
            if (!load_second_q) begin
               load_second_d = 1'b1;
               ready_d       = 1'b1;
            end else begin
               state_d    = S_GROW;
               grow_cnt_d = '0;
            end
         end
         S_GROW: begin
            if (grow_cnt_q == GROW_W'(GROW_CYCLES - 1)) begin
               state_d  = S_MERGE;
               settle_d = '0;
               quiet_d  = '0;
            end else begin
               grow_cnt_d = grow_cnt_q + 1'b1;
            end
         end
         S_MERGE: begin
            // busy_any is stale until the stage and OR-tree pipelines have flushed
            if (settle_q != SETTLE_W'(SETTLE)) begin
               settle_d = settle_q + 1'b1;
            end else begin
               quiet_d = quiet_next;
               if (quiet_next == QUIET_W'(MERGE_QUIET)) begin
                  iter_d = iter_inc;
                  if (!bus.odd_any) begin
                     state_d = S_RESULT;
                     error_d = 1'b0;
                  end else if (iter_inc == ITER_WIDTH'(MAX_ITERATIONS)) begin
                     state_d = S_RESULT;
                     error_d = 1'b1;
                  end else begin
                     state_d    = S_GROW;
                     grow_cnt_d = '0;
                  end
               end
            end
         end
         S_RESULT: begin
            if (bus.result_ack) begin
               state_d = S_IDLE;
               error_d = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase

      stage_d        = stage_of(state_d);
      result_valid_d = (state_d == S_RESULT);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= S_IDLE;
         stage_q        <= STAGE_IDLE;
         load_second_q  <= 1'b0;
         grow_cnt_q     <= '0;
         settle_q       <= '0;
         quiet_q        <= '0;
         iter_q         <= '0;
         ready_q        <= 1'b0;
         result_valid_q <= 1'b0;
         error_q        <= 1'b0;
      end else begin
         state_q        <= state_d;
         stage_q        <= stage_d;
         load_second_q  <= load_second_d;
         grow_cnt_q     <= grow_cnt_d;
         settle_q       <= settle_d;
         quiet_q        <= quiet_d;
         iter_q         <= iter_d;
         ready_q        <= ready_d;
         result_valid_q <= result_valid_d;
         error_q        <= error_d;
      end
   end

   assign bus.global_stage       = stage_q;
   assign bus.measurements_ready = ready_q;
   assign bus.iteration_count    = iter_q;
   assign bus.result_valid       = result_valid_q;
   assign bus.decode_error       = error_q;

`ifdef STAGE_CTRL_STATS_EN
   logic [CYCLE_WIDTH-1:0] total_q, total_d;
   logic [CYCLE_WIDTH-1:0] merge_cyc_q, merge_cyc_d;

   always_comb begin
      total_d     = total_q;
      merge_cyc_d = merge_cyc_q;
      if (state_q == S_IDLE && bus.measurements_valid) begin
         total_d     = '0;
         merge_cyc_d = '0;
      end else begin
         if ((state_q == S_LOAD || state_q == S_GROW || state_q == S_MERGE) && total_q != '1)
            total_d = total_q + 1'b1;
         if (state_q == S_MERGE && merge_cyc_q != '1)
            merge_cyc_d = merge_cyc_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         total_q     <= '0;
         merge_cyc_q <= '0;
      end else begin
         total_q     <= total_d;
         merge_cyc_q <= merge_cyc_d;
      end
   end

   assign bus.total_cycles = total_q;
   assign bus.merge_cycles = merge_cyc_q;
`else
   assign bus.total_cycles = '0;
   assign bus.merge_cycles = '0;
`endif

endmodule

`default_nettype wire
